// File: rtl/nn_pkg.sv
// Shared types and helpers for the perceptron trainer and its step neurons.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } trainer_state_t;

  // Step activation fires only when the weighted sum is strictly above this value.
  localparam int STEP_THRESHOLD = 0;

  // Signed add clamped to the range of a 'width'-bit two's complement value.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned width);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = 33'(a) + 33'(b);
    hi = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo = -(33'sd1 <<< (width - 1));
    if (s > hi) begin
      return 32'(hi);
    end else if (s < lo) begin
      return 32'(lo);
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/step_neuron.sv
// Two-input fixed-weight neuron with step activation.
module step_neuron
  import nn_pkg::*;
#(
  parameter int unsigned W_WIDTH = 8
) (
  input  logic                      a,
  input  logic                      b,
  input  logic signed [W_WIDTH-1:0] w1,
  input  logic signed [W_WIDTH-1:0] w2,
  input  logic signed [W_WIDTH-1:0] bias,
  output logic signed [W_WIDTH+1:0] sum,
  output logic                      y
);

  localparam int unsigned SW = W_WIDTH + 2;

  logic signed [SW-1:0] term_a;
  logic signed [SW-1:0] term_b;
  logic signed [SW-1:0] term_c;

  // Weighted sum at two guard bits, then strict threshold.
  always_comb begin
    term_a = '0;
    term_b = '0;
    if (a) term_a = SW'(w1);
    if (b) term_b = SW'(w2);
    term_c = SW'(bias);
    sum    = term_a + term_b + term_c;
    y      = (32'(sum) > STEP_THRESHOLD);
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Online perceptron-rule trainer for one 2-input step neuron, plus an inference port.
module perceptron_trainer
  import nn_pkg::*;
#(
  parameter int unsigned W_WIDTH    = 8,
  parameter int unsigned LR         = 1,
  parameter int unsigned MAX_EPOCHS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [3:0]                           truth_tbl,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 converged,
  output logic signed [W_WIDTH-1:0]            w1,
  output logic signed [W_WIDTH-1:0]            w2,
  output logic signed [W_WIDTH-1:0]            bias,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]      epochs,
  input  logic                                 infer_a,
  input  logic                                 infer_b,
  output logic                                 infer_y
);

  localparam int unsigned EW = $clog2(MAX_EPOCHS + 1);

  trainer_state_t            state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic                      err_flag_q, err_flag_d;
  logic [3:0]                tt_q, tt_d;
  logic signed [W_WIDTH-1:0] w1_q, w1_d, w2_q, w2_d, bias_q, bias_d;
  logic [EW-1:0]             epochs_q, epochs_d, epochs_inc;
  logic                      converged_q, converged_d;
  logic                      busy_q, busy_d, done_q, done_d;

  logic                      train_y;
  logic                      t_bit;
  logic                      err_nz;
  logic signed [31:0]        delta;
  logic signed [W_WIDTH+1:0] train_sum_unused;
  logic signed [W_WIDTH+1:0] infer_sum_unused;

  // Neuron evaluating the current training sample.
  step_neuron #(.W_WIDTH(W_WIDTH)) u_train_neuron (
    .a    (idx_q[1]),
    .b    (idx_q[0]),
    .w1   (w1_q),
    .w2   (w2_q),
    .bias (bias_q),
    .sum  (train_sum_unused),
    .y    (train_y)
  );

  // Neuron serving the external inference port with the live weights.
  step_neuron #(.W_WIDTH(W_WIDTH)) u_infer_neuron (
    .a    (infer_a),
    .b    (infer_b),
    .w1   (w1_q),
    .w2   (w2_q),
    .bias (bias_q),
    .sum  (infer_sum_unused),
    .y    (infer_y)
  );

  assign t_bit      = tt_q[idx_q];
  assign err_nz     = (t_bit != train_y);
  assign delta      = t_bit ? $signed(32'(LR)) : -$signed(32'(LR));
  assign epochs_inc = epochs_q + EW'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      err_flag_q  <= 1'b0;
      tt_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      bias_q      <= '0;
      epochs_q    <= '0;
      converged_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_flag_q  <= err_flag_d;
      tt_q        <= tt_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      bias_q      <= bias_d;
      epochs_q    <= epochs_d;
      converged_q <= converged_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, epoch bookkeeping and saturating online weight update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_flag_d  = err_flag_q;
    tt_d        = tt_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    bias_d      = bias_q;
    epochs_d    = epochs_q;
    converged_d = converged_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          tt_d        = truth_tbl;
          w1_d        = '0;
          w2_d        = '0;
          bias_d      = '0;
          epochs_d    = '0;
          converged_d = 1'b0;
          err_flag_d  = 1'b0;
          idx_d       = '0;
          state_d     = EVAL;
        end
      end
      EVAL: begin
        if (err_nz) begin
          if (idx_q[1]) w1_d = W_WIDTH'(sat_add(32'(w1_q), delta, W_WIDTH));
          if (idx_q[0]) w2_d = W_WIDTH'(sat_add(32'(w2_q), delta, W_WIDTH));
          bias_d     = W_WIDTH'(sat_add(32'(bias_q), delta, W_WIDTH));
          err_flag_d = 1'b1;
        end
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        epochs_d = epochs_inc;
        if (!err_flag_q) begin
          converged_d = 1'b1;
          state_d     = DONE;
        end else if (epochs_inc == EW'(MAX_EPOCHS)) begin
          converged_d = 1'b0;
          state_d     = DONE;
        end else begin
          err_flag_d = 1'b0;
          idx_d      = '0;
          state_d    = EVAL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = converged_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign bias      = bias_q;
  assign epochs    = epochs_q;

endmodule
